// File: rtl/cbg_bank_responder_if.sv
// rtl/cbg_bank_responder_if.sv - LSU request/response bus between an LSU and its bank responder
// master = LSU side, slave = bank responder side.
interface cbg_bank_responder_if #(
  parameter int ADDR_W = 10
);
  logic [2:0]        R_request;
  logic [34:0]       W_request;
  logic [ADDR_W+1:0] LSU_addr_bus;
  logic [32:0]       CBG_to_LSU_bus;
  logic              ready;

  modport master (
    output R_request,
    output W_request,
    output LSU_addr_bus,
    input  CBG_to_LSU_bus,
    input  ready
  );

  modport slave (
    input  R_request,
    input  W_request,
    input  LSU_addr_bus,
    output CBG_to_LSU_bus,
    output ready
  );
endinterface

// File: rtl/cbg_bank_responder.sv
// rtl/cbg_bank_responder.sv - four-bank 32-bit SRAM responder for LSU loads/stores, 3-stage pipeline
// Optional CBG_INIT_CLEAR_EN: zero all banks after reset before accepting requests.
module cbg_bank_responder #(
  parameter int ADDR_W     = 10,
  parameter int BANK_DEPTH = 1024,
  parameter int CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  cbg_bank_responder_if.slave  bus,
  output logic                 err,
  output logic [CNT_W-1:0]     rd_cnt,
  output logic [CNT_W-1:0]     wr_cnt
);

  localparam int IDX_W = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1;

  logic              ready_q;

  logic              ren_in;
  logic [1:0]        rsel_in;
  logic              wen_in;
  logic [1:0]        wsel_in;
  logic [31:0]       wdata_in;
  logic [ADDR_W-1:0] addr_in;

  logic              s0_ren;
  logic [1:0]        s0_rsel;
  logic              s0_wen;
  logic [1:0]        s0_wsel;
  logic [31:0]       s0_wdata;
  logic [ADDR_W-1:0] s0_addr;
  logic [IDX_W-1:0]  s0_idx;

  logic              in_range;
  logic              rd_ok;
  logic              wr_ok;
  logic              bad_op;

  logic              s1_rvalid;
  logic [31:0]       s1_rdata;

  logic              s2_rvalid;
  logic [31:0]       s2_dout;

  logic [31:0]       mem [4][BANK_DEPTH];

  // addr_sel (upper two bits of LSU_addr_bus) is reserved and deliberately not decoded
  assign ren_in   = bus.R_request[0];
  assign rsel_in  = bus.R_request[2:1];
  assign wen_in   = bus.W_request[32];
  assign wsel_in  = bus.W_request[34:33];
  assign wdata_in = bus.W_request[31:0];
  assign addr_in  = bus.LSU_addr_bus[ADDR_W-1:0];

`ifdef CBG_INIT_CLEAR_EN
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [IDX_W-1:0] clr_q;
  logic             clr_we;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_CLEAR;
      clr_q   <= '0;
    end else begin
      state_q <= state_d;
      if (clr_we) begin
        clr_q <= clr_q + IDX_W'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    clr_we  = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clr_we = 1'b1;
        if (32'(clr_q) == BANK_DEPTH - 1) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_CLEAR;
    endcase
  end

  // ready follows RUN one cycle late so it rises BANK_DEPTH+1 cycles after reset release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= (state_q == ST_RUN);
    end
  end
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b1;
    end
  end
`endif

  assign bus.ready = ready_q;

  // S0: capture request; a not-ready block registers a bubble
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s0_ren   <= 1'b0;
      s0_rsel  <= '0;
      s0_wen   <= 1'b0;
      s0_wsel  <= '0;
      s0_wdata <= '0;
      s0_addr  <= '0;
    end else begin
      s0_ren <= ready_q & ren_in;
      s0_wen <= ready_q & wen_in;
      if (ready_q) begin
        s0_rsel  <= rsel_in;
        s0_wsel  <= wsel_in;
        s0_wdata <= wdata_in;
        s0_addr  <= addr_in;
      end
    end
  end

  assign s0_idx   = s0_addr[IDX_W-1:0];
  assign in_range = (32'(s0_addr) < 32'(BANK_DEPTH));
  assign rd_ok    = s0_ren & in_range;
  assign wr_ok    = s0_wen & in_range;
  assign bad_op   = (s0_ren | s0_wen) & ~in_range;

  // S1 array write; the read below sees pre-edge contents, giving read-first on collision
  always_ff @(posedge clk) begin
`ifdef CBG_INIT_CLEAR_EN
    if (clr_we) begin
      for (int b = 0; b < 4; b++) begin
        mem[b][clr_q] <= '0;
      end
    end else if (wr_ok) begin
      mem[s0_wsel][s0_idx] <= s0_wdata;
    end
`else
    if (wr_ok) begin
      mem[s0_wsel][s0_idx] <= s0_wdata;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_rvalid <= 1'b0;
      s1_rdata  <= '0;
      err       <= 1'b0;
      rd_cnt    <= '0;
      wr_cnt    <= '0;
    end else begin
      s1_rvalid <= rd_ok;
      if (rd_ok) begin
        s1_rdata <= mem[s0_rsel][s0_idx];
      end
      if (bad_op) begin
        err <= 1'b1;
      end
      if (rd_ok && (rd_cnt != {CNT_W{1'b1}})) begin
        rd_cnt <= rd_cnt + CNT_W'(1);
      end
      if (wr_ok && (wr_cnt != {CNT_W{1'b1}})) begin
        wr_cnt <= wr_cnt + CNT_W'(1);
      end
    end
  end

  // S2: dout holds its last value between loads since the LSU samples it every cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_rvalid <= 1'b0;
      s2_dout   <= '0;
    end else begin
      s2_rvalid <= s1_rvalid;
      if (s1_rvalid) begin
        s2_dout <= s1_rdata;
      end
    end
  end

  assign bus.CBG_to_LSU_bus = {s2_rvalid, s2_dout};

endmodule
